// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU encoding and ID/EX control/register records.
package mips_pkg;

  // Primary opcodes handled by the execute stage.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // R-type function codes.
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU function codes, shared with the ALU itself.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  // Operand 1 comes from rs except for shifts, which shift rt.
  typedef enum logic {
    IN1_RS = 1'b0,
    IN1_RT = 1'b1
  } in1_sel_e;

  // Operand 2 is rt, the shift amount, or the sign-extended immediate.
  typedef enum logic [1:0] {
    IN2_RT    = 2'd0,
    IN2_SHAMT = 2'd1,
    IN2_IMM   = 2'd2
  } in2_sel_e;

  // Destination register field; NONE yields register 0.
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2
  } dst_sel_e;

  typedef struct packed {
    logic [2:0] aluop;
    in1_sel_e   in1_sel;
    in2_sel_e   in2_sel;
    dst_sel_e   dst_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch_eq;
    logic       illegal;
  } ctrl_t;

  // Contents of the ID/EX pipeline register; all-zero is a bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  aluop;
    logic [31:0] rt_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_eq;
    logic [31:0] branch_target;
    logic        illegal;
  } ex_regs_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Combinational decode of opcode/funct into ALU function, operand selects and control bits.
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  // Unsupported encodings fall through to the illegal record with every side effect cleared.
  always_comb begin
    ctrl_o         = '0;
    ctrl_o.aluop   = ALU_ADD;
    ctrl_o.in1_sel = IN1_RS;
    ctrl_o.in2_sel = IN2_RT;
    ctrl_o.dst_sel = DST_NONE;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.dst_sel   = DST_RD;
        ctrl_o.reg_write = 1'b1;
        case (funct_i)
          FN_ADD: ctrl_o.aluop = ALU_ADD;
          FN_SUB: ctrl_o.aluop = ALU_SUB;
          FN_AND: ctrl_o.aluop = ALU_AND;
          FN_OR:  ctrl_o.aluop = ALU_OR;
          FN_SLT: ctrl_o.aluop = ALU_SLT;
          FN_NOR: ctrl_o.aluop = ALU_NOR;
          FN_SLL: begin
            ctrl_o.aluop   = ALU_SLL;
            ctrl_o.in1_sel = IN1_RT;
            ctrl_o.in2_sel = IN2_SHAMT;
          end
          FN_SRL: begin
            ctrl_o.aluop   = ALU_SRL;
            ctrl_o.in1_sel = IN1_RT;
            ctrl_o.in2_sel = IN2_SHAMT;
          end
          default: begin
            ctrl_o.dst_sel   = DST_NONE;
            ctrl_o.reg_write = 1'b0;
            ctrl_o.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_o.in2_sel   = IN2_IMM;
        ctrl_o.dst_sel   = DST_RT;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.in2_sel   = IN2_IMM;
        ctrl_o.dst_sel   = DST_RT;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
      end
      OP_SW: begin
        ctrl_o.in2_sel   = IN2_IMM;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.aluop     = ALU_SUB;
        ctrl_o.branch_eq = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand muxing, sign extension, branch target and stall/flush control.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc_plus4,
  output logic        ex_valid,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  aluop,
  output logic [31:0] ex_rt_data,
  output logic [4:0]  ex_dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch_eq,
  output logic [31:0] branch_target,
  output logic        illegal
);

  ctrl_t       ctrl;
  logic [31:0] imm32;
  logic [4:0]  dest;
  ex_regs_t    ex_d;
  ex_regs_t    ex_q;
  logic        unused_rs_field;

  // The rs field is not needed here because rs_data already arrives from the register file.
  assign unused_rs_field = ^instr[25:21];

  alu_ctrl u_alu_ctrl (
    .opcode_i (instr[31:26]),
    .funct_i  (instr[5:0]),
    .ctrl_o   (ctrl)
  );

  assign imm32 = sext16(instr[15:0]);

  // Build the next register contents for a valid instruction; writes to $0 are suppressed.
  always_comb begin
    case (ctrl.dst_sel)
      DST_RD:  dest = instr[15:11];
      DST_RT:  dest = instr[20:16];
      default: dest = 5'd0;
    endcase

    ex_d         = '0;
    ex_d.valid   = 1'b1;
    ex_d.alu_in1 = (ctrl.in1_sel == IN1_RT) ? rt_data : rs_data;
    case (ctrl.in2_sel)
      IN2_SHAMT: ex_d.alu_in2 = {27'd0, instr[10:6]};
      IN2_IMM:   ex_d.alu_in2 = imm32;
      default:   ex_d.alu_in2 = rt_data;
    endcase
    ex_d.aluop         = ctrl.aluop;
    ex_d.rt_data       = rt_data;
    ex_d.dest          = dest;
    ex_d.reg_write     = ctrl.reg_write && (dest != 5'd0);
    ex_d.mem_read      = ctrl.mem_read;
    ex_d.mem_write     = ctrl.mem_write;
    ex_d.branch_eq     = ctrl.branch_eq;
    ex_d.branch_target = pc_plus4 + {imm32[29:0], 2'b00};
    ex_d.illegal       = ctrl.illegal;
  end

  // Reset and flush load a bubble, stall holds, otherwise latch the instruction or a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= in_valid ? ex_d : '0;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign alu_in1       = ex_q.alu_in1;
  assign alu_in2       = ex_q.alu_in2;
  assign aluop         = ex_q.aluop;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_dest       = ex_q.dest;
  assign reg_write     = ex_q.reg_write;
  assign mem_read      = ex_q.mem_read;
  assign mem_write     = ex_q.mem_write;
  assign branch_eq     = ex_q.branch_eq;
  assign branch_target = ex_q.branch_target;
  assign illegal       = ex_q.illegal;

endmodule
